gate_sweep_ctrl: RTL and testbench

- Self-checking sequencer for a combinational logic gate such as a 2-input AND.
- On request it drives the gate inputs through every input combination.
- It holds each vector for a programmable settle time and samples the gate output, comparing it against an expected truth table.
- It reports pass/fail, the error count and the first failing vector. It sits beside the gate under test and replaces hand-written stimulus.

---
 rtl/gate_sweep_ctrl.sv | 106 ++++++++++
 tb/tb_gate_sweep_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Drives a combinational gate through all 2^N_IN input vectors, holding each for SETTLE cycles,
// and checks the sampled output against TRUTH_TABLE, reporting pass, error count and first failure.
module gate_sweep_ctrl #(
  parameter int                      N_IN        = 2,
  parameter int                      SETTLE      = 2,
  parameter logic [(1<<N_IN)-1:0]    TRUTH_TABLE = 4'b1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            gate_out,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_idx
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] V_LAST   = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N_IN-1:0] v;
  logic [CW-1:0]   cnt;
  logic            sample;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;

  always_comb begin
    sample   = (state == RUN) && (cnt == CNT_LAST);
    mismatch = sample && (gate_out != TRUTH_TABLE[v]);
    err_nxt  = err_count + {{N_IN{1'b0}}, mismatch};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        // abort takes priority even on the edge that samples the last vector
        if (abort)                         state_nxt = IDLE;
        else if (sample && (v == V_LAST))  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v               <= '0;
      cnt             <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            v               <= '0;
            cnt             <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            if (sample) begin
              cnt       <= '0;
              v         <= v + 1'b1;
              err_count <= err_nxt;
              if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= v;
              end
              // pass must already be valid during the DONE cycle
              if (v == V_LAST) pass <= (err_nxt == '0);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign gate_in = busy ? v : '0;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: a 2-input gate model with selectable behaviour (AND, stuck-at-0, OR) on one
// instance and a 3-input AND on a second instance with SETTLE=1.
module tb_gate_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start_a, abort_a, gate_out_a;
  logic [1:0] gate_in_a;
  logic       busy_a, done_a, pass_a, fev_a;
  logic [2:0] err_a;
  logic [1:0] idx_a;

  logic       start_b, abort_b, gate_out_b;
  logic [2:0] gate_in_b;
  logic       busy_b, done_b, pass_b, fev_b;
  logic [3:0] err_b;
  logic [2:0] idx_b;

  int mode;  // 0 = AND, 1 = stuck at 0, 2 = OR
  int n_chk;
  int n_fail;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(2), .TRUTH_TABLE(4'b1000)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .gate_out(gate_out_a),
    .gate_in(gate_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_valid(fev_a), .first_err_idx(idx_a)
  );

  gate_sweep_ctrl #(.N_IN(3), .SETTLE(1), .TRUTH_TABLE(8'b1000_0000)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .gate_out(gate_out_b),
    .gate_in(gate_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_valid(fev_b), .first_err_idx(idx_b)
  );

  always_comb begin
    case (mode)
      1:       gate_out_a = 1'b0;
      2:       gate_out_a = |gate_in_a;
      default: gate_out_a = &gate_in_a;
    endcase
    gate_out_b = &gate_in_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero_a(input string tag);
    chk({tag, ".gate_in"}, 32'(gate_in_a), 0);
    chk({tag, ".busy"},    32'(busy_a),    0);
    chk({tag, ".done"},    32'(done_a),    0);
    chk({tag, ".pass"},    32'(pass_a),    0);
    chk({tag, ".err"},     32'(err_a),     0);
    chk({tag, ".fev"},     32'(fev_a),     0);
    chk({tag, ".idx"},     32'(idx_a),     0);
  endtask

  // Full sweep on dut_a from IDLE; called at a negedge, returns at a negedge in IDLE.
  task automatic sweep_a(input string tag, input int exp_err, input int exp_idx,
                         input bit exp_fev, input bit spam);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, ".clr_err"},  32'(err_a),  0);
    chk({tag, ".clr_fev"},  32'(fev_a),  0);
    chk({tag, ".clr_pass"}, 32'(pass_a), 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s.gate_in[c%0d]", tag, k + 1), 32'(gate_in_a), k / 2);
      chk($sformatf("%s.busy[c%0d]", tag, k + 1),    32'(busy_a),    1);
      chk($sformatf("%s.done[c%0d]", tag, k + 1),    32'(done_a),    0);
      start_a = spam && (k == 4);
      @(negedge clk);
    end
    start_a = 1'b0;
    chk({tag, ".done"},    32'(done_a),    1);
    chk({tag, ".busy_d"},  32'(busy_a),    0);
    chk({tag, ".gin_d"},   32'(gate_in_a), 0);
    chk({tag, ".pass"},    32'(pass_a),    (exp_err == 0) ? 1 : 0);
    chk({tag, ".err"},     32'(err_a),     exp_err);
    chk({tag, ".fev"},     32'(fev_a),     exp_fev);
    chk({tag, ".idx"},     32'(idx_a),     exp_idx);
    start_a = spam;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, ".idle_busy"}, 32'(busy_a), 0);
    chk({tag, ".idle_done"}, 32'(done_a), 0);
    chk({tag, ".hold_pass"}, 32'(pass_a), (exp_err == 0) ? 1 : 0);
    chk({tag, ".hold_err"},  32'(err_a),  exp_err);
    chk({tag, ".hold_idx"},  32'(idx_a),  exp_idx);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    mode    = 0;
    reset   = 1'b1;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero_a("reset");
    chk("reset.b_busy", 32'(busy_b), 0);
    reset = 1'b0;
    @(negedge clk);

    sweep_a("and", 0, 0, 0, 0);

    mode = 1;
    sweep_a("stuck0", 1, 3, 1, 0);

    mode = 2;
    sweep_a("or", 2, 1, 1, 0);

    // abort while v=2: only the v=1 mismatch has been sampled
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort.pre_gin", 32'(gate_in_a), 2);
    chk("abort.pre_err", 32'(err_a), 1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort.busy", 32'(busy_a),    0);
    chk("abort.gin",  32'(gate_in_a), 0);
    chk("abort.done", 32'(done_a),    0);
    chk("abort.pass", 32'(pass_a),    0);
    chk("abort.err",  32'(err_a),     1);
    chk("abort.fev",  32'(fev_a),     1);
    chk("abort.idx",  32'(idx_a),     1);
    @(negedge clk);
    chk("abort.done2", 32'(done_a), 0);

    // reset at v=1 then a clean sweep
    mode    = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid.gin", 32'(gate_in_a), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero_a("rst_mid");
    sweep_a("post_rst", 0, 0, 0, 0);

    // start pulsed during RUN and DONE must not restart
    sweep_a("spam", 0, 0, 0, 1);

    // abort coinciding with the final sample edge: no done, last mismatch not counted
    mode    = 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_last.gin", 32'(gate_in_a), 3);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_last.done", 32'(done_a), 0);
    chk("abort_last.busy", 32'(busy_a), 0);
    chk("abort_last.err",  32'(err_a),  0);
    chk("abort_last.pass", 32'(pass_a), 0);

    // start and abort together in IDLE: start wins
    mode    = 0;
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("start_abort.busy", 32'(busy_a), 1);
    repeat (8) @(negedge clk);
    chk("start_abort.done", 32'(done_a), 1);
    chk("start_abort.pass", 32'(pass_a), 1);

    // 3-input AND with SETTLE=1
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b.gate_in[c%0d]", k + 1), 32'(gate_in_b), k);
      chk($sformatf("b.busy[c%0d]", k + 1),    32'(busy_b),    1);
      @(negedge clk);
    end
    chk("b.done", 32'(done_b), 1);
    chk("b.pass", 32'(pass_b), 1);
    chk("b.err",  32'(err_b),  0);
    chk("b.fev",  32'(fev_b),  0);
    @(negedge clk);
    chk("b.idle", 32'(busy_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
